// File: rtl/keyboard_ctrl.sv
// PS/2 keyboard receiver and key-state decoder.
// Deserializes device-to-host frames, tracks E0/F0 prefixes and drives
// per-player held levels: bit 0 = WASD (Tom), bit 1 = arrows (Jerry).
module keyboard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] left,
    output logic [1:0] right,
    output logic [1:0] jump,
    output logic [1:0] stay,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic             clk_s1, clk_s2, clk_s3;
    logic             data_s1, data_s2;
    logic             fall;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic [7:0]       shift;
    logic             par;
    logic             byte_valid;
    logic             ext;
    logic             brk;

    // Two-FF synchronizers plus a third clock stage for edge detection;
    // reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    // Frame FSM: start/data/parity/stop capture with inter-edge timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            to_cnt     <= '0;
            shift      <= 8'd0;
            par        <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        if (data_s2 && (^{shift, par})) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt    <= '0;
                    state     <= IDLE;
                    frame_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + CNT_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Decoder: prefix tracking and make/break updates of the held levels.
    // Any frame error drops a pending prefix so a partial sequence resyncs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            left  <= 2'b00;
            right <= 2'b00;
            jump  <= 2'b00;
            stay  <= 2'b00;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            case (shift)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    case ({ext, shift})
                        9'h01C:  left[0]  <= ~brk;
                        9'h023:  right[0] <= ~brk;
                        9'h01D:  jump[0]  <= ~brk;
                        9'h01B:  stay[0]  <= ~brk;
                        9'h16B:  left[1]  <= ~brk;
                        9'h174:  right[1] <= ~brk;
                        9'h175:  jump[1]  <= ~brk;
                        9'h172:  stay[1]  <= ~brk;
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Directed bench for keyboard_ctrl: PS/2 frames driven bit by bit.
module tb_keyboard_ctrl;

    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] left, right, jump, stay;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_total = 0;
    int err_base;

    keyboard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .left      (left),
        .right     (right),
        .jump      (jump),
        .stay      (stay),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count frame_err cycles; a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (frame_err) err_total = err_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, then a low/high clock phase.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] code, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ flip);
    endtask

    task automatic send_byte(input logic [7:0] code, input logic flip);
        send_head(code, flip);
        ps2_bit(1'b1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {left, right, jump, stay}, 32'h0);
        check("reset_err", frame_err, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        err_base = err_total;

        // 0x1C with exact latency: stop-bit fall, sync, detect, byte_valid, update
        send_head(8'h1C, 1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_before_latency", left, 32'h0);
        @(posedge clk);
        #1;
        check("a_make", left, 32'h1);
        check("a_others", {right, jump, stay}, 32'h0);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        send_byte(8'hF0, 1'b0);
        check("f0_alone", left, 32'h1);
        send_byte(8'h1C, 1'b0);
        check("a_break", left, 32'h0);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h74, 1'b0);
        check("rarrow_make", right, 32'h2);
        send_byte(8'h23, 1'b0);
        check("d_make", right, 32'h3);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h74, 1'b0);
        check("rarrow_break", right, 32'h1);
        check("no_err_valid", err_total - err_base, 32'd0);

        // Even parity on 0x1D must be rejected with a single-cycle pulse
        err_base = err_total;
        send_byte(8'h1D, 1'b1);
        check("parity_err_pulse", err_total - err_base, 32'd1);
        check("parity_discard", jump, 32'h0);
        send_byte(8'h1D, 1'b0);
        check("w_make", jump, 32'h1);
        send_byte(8'h1D, 1'b0);
        check("w_typematic", jump, 32'h1);

        // Truncated frame then a stall longer than the timeout
        err_base = err_total;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 20) @(posedge clk);
        #1;
        check("timeout_pulse", err_total - err_base, 32'd1);
        send_byte(8'h1B, 1'b0);
        check("s_after_timeout", stay, 32'h1);
        check("timeout_no_extra", err_total - err_base, 32'd1);

        // E0 pending across a reset must not extend the following 6B
        send_byte(8'hE0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_outs", {left, right, jump, stay}, 32'h0);
        check("rst_err", frame_err, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'h6B, 1'b0);
        check("keypad_6b_unmapped", {left, right, jump, stay}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
